// File: rtl/data_mem_responder.sv
// Data-memory responder: one load/store at a time, fixed latency, little-endian byte/half/word with extension.
// Optional DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses report an error instead of being force-aligned.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    state_t state, state_next;

    logic [CW-1:0] cnt;
    logic          cap_write;
    logic [31:0]   cap_addr;
    logic [31:0]   cap_wdata;
    logic [1:0]    cap_size;
    logic          cap_unsigned;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          do_access;
    logic          acc_err;
    logic [AW-1:0] idx;
    logic [1:0]    off;
    logic [31:0]   rd_word;
    logic [31:0]   ld_data;
    logic [31:0]   st_data;
    logic [3:0]    st_mask;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        do_access  = 1'b0;
        case (state)
            IDLE: if (req_valid) state_next = BUSY;
            BUSY: if (cnt == '0) begin
                do_access  = 1'b1;
                state_next = RESP;
            end
            RESP: if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    // Address decode: off is the effective lane offset after force-alignment.
    always_comb begin
        idx     = cap_addr[AW+1:2];
        off     = cap_addr[1:0];
        if (cap_size == 2'b01) off[0] = 1'b0;
        if (cap_size == 2'b10) off    = 2'b00;
        acc_err = (cap_size == 2'b11) || (|cap_addr[31:AW+2]);
`ifdef DMEM_MISALIGN_TRAP_EN
        if ((cap_size == 2'b01 && cap_addr[0]) || (cap_size == 2'b10 && cap_addr[1:0] != 2'b00))
            acc_err = 1'b1;
`endif
    end

    assign rd_word = mem[idx];

    always_comb begin
        ld_data = '0;
        st_data = cap_wdata;
        st_mask = 4'b0000;
        case (cap_size)
            2'b00: begin
                case (off)
                    2'd0:    ld_data[7:0] = rd_word[7:0];
                    2'd1:    ld_data[7:0] = rd_word[15:8];
                    2'd2:    ld_data[7:0] = rd_word[23:16];
                    default: ld_data[7:0] = rd_word[31:24];
                endcase
                if (!cap_unsigned) ld_data[31:8] = {24{ld_data[7]}};
                st_data = {4{cap_wdata[7:0]}};
                st_mask = 4'b0001 << off;
            end
            2'b01: begin
                ld_data[15:0] = off[1] ? rd_word[31:16] : rd_word[15:0];
                if (!cap_unsigned) ld_data[31:16] = {16{ld_data[15]}};
                st_data = {2{cap_wdata[15:0]}};
                st_mask = off[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                ld_data = rd_word;
                st_mask = 4'b1111;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= '0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
            cap_write    <= 1'b0;
            cap_addr     <= '0;
            cap_wdata    <= '0;
            cap_size     <= '0;
            cap_unsigned <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    cap_write    <= req_write;
                    cap_addr     <= req_addr;
                    cap_wdata    <= req_wdata;
                    cap_size     <= req_size;
                    cap_unsigned <= req_unsigned;
                    cnt          <= CW'(LATENCY - 1);
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        rsp_rdata <= (acc_err || cap_write) ? '0 : ld_data;
                        rsp_err   <= acc_err;
                    end
                end
                RESP: if (rsp_ready) begin
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Reset on the commit edge must suppress the store, hence the explicit gate.
    always_ff @(posedge clk) begin
        if (!reset && do_access && cap_write && !acc_err) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (st_mask[i]) mem[idx][8*i +: 8] <= st_data[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench for data_mem_responder against a byte-array reference model.
// Honours DMEM_MISALIGN_TRAP_EN the same way as the design.
module tb_data_mem_responder;
    localparam int DEPTH = 64;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic [7:0]  mem_m [DEPTH*4];
    int          n_checks = 0;
    int          n_fail   = 0;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: byte-addressed memory, access size in bytes, alignment by modulo.
    task automatic model(input logic w, input logic [31:0] a, input logic [31:0] wd,
                         input logic [1:0] sz, input logic uns,
                         output logic [31:0] rd, output logic e);
        int unsigned nb;
        int unsigned base;
        logic [31:0] val;
        rd = 0;
        e  = 0;
        if (sz == 2'b11 || a >= DEPTH*4) begin
            e = 1;
        end else begin
            nb   = 1 << sz;
            base = a - (a % nb);
`ifdef DMEM_MISALIGN_TRAP_EN
            if (a % nb != 0) e = 1;
`endif
            if (!e) begin
                if (w) begin
                    for (int unsigned i = 0; i < nb; i++) mem_m[base+i] = wd[8*i +: 8];
                end else begin
                    val = 0;
                    for (int unsigned i = 0; i < nb; i++) val = val | (32'(mem_m[base+i]) << (8*i));
                    if (!uns && nb < 4 && val[8*nb-1]) val = val | ~((32'd1 << (8*nb)) - 1);
                    rd = val;
                end
            end
        end
    endtask

    task automatic do_txn(input logic w, input logic [31:0] a, input logic [31:0] wd,
                          input logic [1:0] sz, input logic uns, input int hold,
                          output logic [31:0] got_rd);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          edges;
        model(w, a, wd, sz, uns, exp_rd, exp_err);
        @(negedge clk);
        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1; req_write = w; req_addr = a; req_wdata = wd; req_size = sz; req_unsigned = uns;
        @(posedge clk); #1;
        check("busy_rsp_valid", 32'(rsp_valid), 32'd0);
        check("busy_req_ready", 32'(req_ready), 32'd0);
        req_valid = 1'($urandom); req_write = 1'($urandom); req_addr = $urandom;
        req_wdata = $urandom; req_size = 2'($urandom); req_unsigned = 1'($urandom);
        edges = 0;
        while (!rsp_valid && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        check("latency", 32'(edges), 32'(LAT));
        got_rd = rsp_rdata;
        check("rsp_rdata", rsp_rdata, exp_rd);
        check("rsp_err", 32'(rsp_err), 32'(exp_err));
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_rdata", rsp_rdata, exp_rd);
            check("hold_err", 32'(rsp_err), 32'(exp_err));
            check("hold_req_ready", 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        req_valid = 0;
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
        check("post_rsp_valid", 32'(rsp_valid), 32'd0);
        check("post_req_ready", 32'(req_ready), 32'd1);
    endtask

    logic [31:0] r;
    logic [1:0]  rsz;
    logic [31:0] raddr;

    initial begin
        reset = 1; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
        req_size = 0; req_unsigned = 0; rsp_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rdata", rsp_rdata, 32'd0);
        check("reset_err", 32'(rsp_err), 32'd0);
        @(negedge clk);
        reset = 0;

        for (int i = 0; i < DEPTH; i++)
            do_txn(1, 32'(i*4), (i == 8) ? 32'h11223344 : $urandom, 2'b10, 0, 0, r);

        do_txn(1, 32'h10, 32'hDEADBEEF, 2'b10, 0, 0, r);
        do_txn(0, 32'h10, 0, 2'b10, 0, 0, r);
        check("word_dead", r, 32'hDEADBEEF);
        do_txn(0, 32'h11, 0, 2'b00, 0, 0, r);
        check("byte_signed", r, 32'hFFFFFFBE);
        do_txn(0, 32'h11, 0, 2'b00, 1, 0, r);
        check("byte_unsigned", r, 32'h000000BE);
        do_txn(1, 32'h12, 32'h00001234, 2'b01, 0, 0, r);
        do_txn(0, 32'h10, 0, 2'b10, 0, 0, r);
        check("half_merge", r, 32'h1234BEEF);
        do_txn(0, 32'h13, 0, 2'b10, 0, 0, r);
        do_txn(1, 32'h13, 32'h55667788, 2'b10, 0, 0, r);
        do_txn(0, 32'h10, 0, 2'b10, 0, 0, r);
        do_txn(0, 32'h100, 0, 2'b10, 0, 0, r);
        do_txn(1, 32'h100, 32'hA5A5A5A5, 2'b10, 0, 0, r);
        do_txn(1, 32'h0, 32'hA5A5A5A5, 2'b11, 0, 0, r);
        do_txn(0, 32'h0, 0, 2'b11, 0, 0, r);
        do_txn(0, 32'h0, 0, 2'b10, 0, 0, r);
        do_txn(0, 32'h10, 0, 2'b10, 0, 3, r);

        // Reset one cycle after accepting a store: the store must be dropped.
        @(negedge clk);
        req_valid = 1; req_write = 1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
        req_size = 2'b10; req_unsigned = 0;
        @(posedge clk); #1;
        req_valid = 0;
        @(negedge clk);
        reset = 1;
        @(posedge clk); #1;
        check("rst_busy_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy_req_ready", 32'(req_ready), 32'd1);
        check("rst_busy_rdata", rsp_rdata, 32'd0);
        @(negedge clk);
        reset = 0;
        do_txn(0, 32'h20, 0, 2'b10, 0, 0, r);
        check("dropped_store", 32'(r == 32'hCAFEF00D), 32'd0);

        for (int n = 0; n < 250; n++) begin
            rsz   = 2'($urandom_range(0, 3));
            raddr = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 32'h10F));
            do_txn(1'($urandom), raddr, $urandom, rsz, 1'($urandom), $urandom_range(0, 2), r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
